fifo_wr_arb: RTL and testbench

- Write-side controller for the async FIFO storage array, living entirely in the wclk domain.
- Shares the single memory write port (wclken/waddr/wdata) among NUM_REQ requesters using round-robin arbitration with burst lock.
- Owns the write pointer (binary and Gray), computes wfull against the synchronized read pointer, and exports the Gray write pointer for synchronization into the read domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fifo_wr_arb.sv | 102 ++++++++++
 tb/tb_fifo_wr_arb.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write/read controllers.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational circular-priority picker: first set request at or after rr_ptr_i.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic               any_o,
  output logic [GW-1:0]      idx_o
);

  // rot[k] is the request of requester (rr_ptr_i + k) mod NUM_REQ
  logic [NUM_REQ-1:0] rot;
  assign rot = NUM_REQ'({req_i, req_i} >> rr_ptr_i);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        idx_o = GW'((int'(rr_ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Write-side FIFO controller: round-robin burst-locked arbitration onto the single
// memory write port, plus the binary/Gray write pointer and registered full flag.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH:0]           wq2_rptr,
  output logic [ADDR_WIDTH:0]           wptr,
  output logic                          wfull,
  output logic                          wclken,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [GW-1:0]                 gnt_id,
  output logic                          busy
);

  localparam int AW = ADDR_WIDTH;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [AW:0]   wbin_q, wbin_d;
  logic [AW:0]   wgray_q, wgray_d;
  logic          wfull_q, wfull_d;
  logic          arb_any;
  logic [GW-1:0] arb_idx;
  logic          accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (req_valid),
    .rr_ptr_i (rr_q),
    .any_o    (arb_any),
    .idx_o    (arb_idx)
  );

  // Accepts are suppressed in the reset cycle so a mid-burst reset never writes.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!wfull_q && !wrst) req_ready = NUM_REQ'(1) << gnt_q;
        accept = req_valid[gnt_q] & ~wfull_q & ~wrst;
        if (accept && req_last[gnt_q]) begin
          state_d = IDLE;
          rr_d    = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wbin_d  = wbin_q + (AW+1)'(accept);
  assign wgray_d = (AW+1)'(bin2gray(32'(wbin_d)));
  assign wfull_d = (wgray_d == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  assign wptr   = wgray_q;
  assign wfull  = wfull_q;
  assign wclken = accept;
  assign waddr  = wbin_q[AW-1:0];
  assign wdata  = req_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_id = gnt_q;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a transaction-count reference model.
module tb_fifo_wr_arb;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            wrst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [AW:0]     wq2_rptr, wptr;
  logic            wfull, wclken, busy;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [GW-1:0]   gnt_id;

  fifo_wr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .wclk      (clk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wq2_rptr  (wq2_rptr),
    .wptr      (wptr),
    .wfull     (wfull),
    .wclken    (wclken),
    .waddr     (waddr),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  // Reference model: grant owner, round-robin pointer, total writes, reader progress.
  bit m_grant, m_full;
  int m_gid, m_rr, m_wr;
  int rd_cnt, rd_s1, rd_s2;
  int rem [N];

  initial begin
    bit rst_now, exp_rdy, exp_acc, found;
    int rate, max_fill, n_full_cyc;
    logic [DW-1:0] slice;
    wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; wq2_rptr = '0;
    m_grant = 0; m_full = 0; m_gid = 0; m_rr = 0; m_wr = 0;
    rd_cnt = 0; rd_s1 = 0; rd_s2 = 0; n_full_cyc = 0; max_fill = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 4500; cyc++) begin
      @(negedge clk);
      rst_now = (cyc < 2) || ($urandom_range(0, 299) == 0);
      wrst = rst_now;
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 1) == 1) rem[i] = $urandom_range(1, 4);
        req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 3) != 0);
        req_last[i]  = (rem[i] == 1);
        req_data[i*DW +: DW] = $urandom;
      end
      wq2_rptr = gray(rd_s2);
      #1;

      exp_rdy = m_grant && !m_full && !rst_now;
      exp_acc = exp_rdy && req_valid[m_gid];
      slice   = req_data[m_gid*DW +: DW];
      check("busy",      busy,      m_grant);
      check("gnt_id",    gnt_id,    m_gid);
      check("wfull",     wfull,     m_full);
      check("wptr",      wptr,      gray(m_wr));
      check("wclken",    wclken,    exp_acc);
      check("req_ready", req_ready, exp_rdy ? (64'd1 << m_gid) : 64'd0);
      check("waddr",     waddr,     m_wr % 16);
      check("wdata",     wdata,     slice);

      if (exp_acc) rem[m_gid]--;
      if (m_full) n_full_cyc++;

      if (rst_now) begin
        m_grant = 0; m_full = 0; m_gid = 0; m_rr = 0; m_wr = 0;
        rd_cnt = 0; rd_s1 = 0; rd_s2 = 0;
      end else begin
        if (!m_grant) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_rr + k) % N]) begin
              found = 1; m_grant = 1; m_gid = (m_rr + k) % N;
            end
          end
        end else if (exp_acc && req_last[m_gid]) begin
          m_grant = 0;
          m_rr = (m_gid + 1) % N;
        end
        m_wr += int'(exp_acc);
        m_full = ((m_wr - rd_s2) == 16);
        if (m_wr - rd_s2 > max_fill) max_fill = m_wr - rd_s2;
        rate = (cyc < 1500) ? 1 : (cyc < 3000) ? 9 : 5;
        rd_s2 = rd_s1;
        rd_s1 = rd_cnt;
        if (rd_cnt < m_wr && $urandom_range(0, 9) < rate) rd_cnt++;
      end
    end

    check("full_reached", n_full_cyc > 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
